// File: rtl/mux_sel_scanner_pkg.sv
// mux_sel_scanner_pkg: shared state encodings, channel constants and counter sizing helper
// Contents: state_t (ST_IDLE/ST_SCAN), N_CH, SEL_W, DWELL_MAX, cnt_w()
package mux_sel_scanner_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;
    localparam int N_CH      = 4;
    localparam int SEL_W     = 2;
    localparam int DWELL_MAX = 16;
    // Counter width for a dwell of d cycles; a dwell of 1 still needs a 1-bit register
    function automatic int cnt_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts 0..DWELL-1 while enabled and flags the last count of each dwell
// Ports: clk, rst (async, active-high), en (count), clr (restart at 0), wrap (en at count DWELL-1)
module dwell_counter
    import mux_sel_scanner_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int W = cnt_w(DWELL);
    logic [W-1:0] cnt;
    assign wrap = en && (cnt == W'(DWELL - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/mux_case.sv
// mux_case: 4:1 case-statement multiplexer fed by the scanner
// Ports: in (4 data bits), sel (channel), out (in[sel])
module mux_case (
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out
);
    always_comb begin
        out = 1'b0;
        case (sel)
            2'd0: out = in[0];
            2'd1: out = in[1];
            2'd2: out = in[2];
            2'd3: out = in[3];
            default: out = 1'b0;
        endcase
    end
endmodule

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: captures a word via valid/ready and steps the mux select through all channels
// Ports: clk, rst (async, active-high), load/data (upstream word), abort (frame cancel),
//        ready, in (registered word), sel (registered select), slot_valid, frame_done
module mux_sel_scanner
    import mux_sel_scanner_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [3:0]       data,
    input  logic             abort,
    output logic             ready,
    output logic [3:0]       in,
    output logic [SEL_W-1:0] sel,
    output logic             slot_valid,
    output logic             frame_done
);
    state_t state;
    logic   scan, wrap, last, clr;
    assign scan       = (state == ST_SCAN);
    assign slot_valid = scan;
    assign last       = scan && (sel == SEL_W'(N_CH - 1)) && wrap;
    // abort suppresses both end-of-frame strobes so a coincident load is dropped
    assign frame_done = last && !abort;
    assign ready      = !scan || frame_done;
    assign clr        = (scan && abort) || (load && ready);

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .en   (scan),
        .clr  (clr),
        .wrap (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            in    <= '0;
            sel   <= '0;
        end else if (scan && abort) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else if (load && ready) begin
            state <= ST_SCAN;
            in    <= data;
            sel   <= '0;
        end else if (last) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else if (wrap) begin
            sel <= sel + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb_mux_sel_scanner: directed checks of the scanner (DWELL=1 and DWELL=3) driving mux_case
module tb_mux_sel_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load1 = 1'b0, abort1 = 1'b0, load3 = 1'b0, abort3 = 1'b0;
    logic [3:0] data1 = 4'h0, data3 = 4'h0;
    logic       ready1, sv1, fd1, out1, ready3, sv3, fd3, out3;
    logic [3:0] in1, in3;
    logic [1:0] sel1, sel3;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    mux_sel_scanner #(.DWELL(1)) u1 (
        .clk(clk), .rst(rst), .load(load1), .data(data1), .abort(abort1),
        .ready(ready1), .in(in1), .sel(sel1), .slot_valid(sv1), .frame_done(fd1)
    );
    mux_case m1 (.in(in1), .sel(sel1), .out(out1));

    mux_sel_scanner #(.DWELL(3)) u3 (
        .clk(clk), .rst(rst), .load(load3), .data(data3), .abort(abort3),
        .ready(ready3), .in(in3), .sel(sel3), .slot_valid(sv3), .frame_done(fd3)
    );
    mux_case m3 (.in(in3), .sel(sel3), .out(out3));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // packed observation {ready, slot_valid, frame_done, sel, out}
    task automatic exp1(input string tag, input logic r, input logic v, input logic f,
                        input logic [1:0] s, input logic o);
        chk(tag, {2'b0, ready1, sv1, fd1, sel1, out1}, {2'b0, r, v, f, s, o});
    endtask

    // DUT1 has just entered SCAN at sel=0 with load low; walk one full frame
    task automatic frame1(input string tag, input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            exp1(tag, i == 3, 1'b1, i == 3, 2'(i), w[i]);
            chk({tag, "_in"}, {4'h0, in1}, {4'h0, w});
            tick();
        end
        exp1({tag, "_end"}, 1'b1, 1'b0, 1'b0, 2'd0, w[0]);
    endtask

    initial begin
        tick();
        exp1("rst_out", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("rst_in", {4'h0, in1}, 8'h00);
        rst = 1'b0;
        tick();
        exp1("idle", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // basic frame, DWELL=1
        load1 = 1'b1; data1 = 4'b0011;
        tick();
        load1 = 1'b0;
        frame1("f0011", 4'b0011);

        // DWELL=3 frame
        load3 = 1'b1; data3 = 4'b1010;
        tick();
        load3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("d3", {2'b0, ready3, sv3, fd3, sel3, out3},
                {2'b0, i == 11, 1'b1, i == 11, 2'(i / 3), 4'b1010 >> (i / 3) & 4'b1 ? 1'b1 : 1'b0});
            tick();
        end
        chk("d3_end", {2'b0, ready3, sv3, fd3, sel3, out3}, 8'b0010_0000);

        // back-to-back frames; the held load is ignored until end of first frame
        load1 = 1'b1; data1 = 4'b0011;
        tick();
        data1 = 4'b1100;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) load1 = 1'b0;
            exp1("b2b", i == 3 || i == 7, 1'b1, i == 3 || i == 7, 2'(i % 4),
                 (i < 4) ? (4'b0011 >> i & 4'b1) != 0 : (4'b1100 >> (i - 4) & 4'b1) != 0);
            chk("b2b_in", {4'h0, in1}, (i < 4) ? 8'h03 : 8'h0c);
            tick();
        end
        exp1("b2b_end", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // abort at sel=01 with a coincident load
        load1 = 1'b1; data1 = 4'b0110;
        tick();
        load1 = 1'b0;
        tick();
        abort1 = 1'b1; load1 = 1'b1; data1 = 4'b1111;
        exp1("abort_cyc", 1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
        tick();
        abort1 = 1'b0; load1 = 1'b0;
        exp1("abort_idle", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("abort_in", {4'h0, in1}, 8'h06);
        tick();
        exp1("abort_stay", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // abort in IDLE has no effect; load is accepted
        abort1 = 1'b1; load1 = 1'b1; data1 = 4'b1001;
        exp1("abort_in_idle", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        abort1 = 1'b0; load1 = 1'b0;
        frame1("f1001", 4'b1001);

        // single-cycle load while busy is ignored
        load1 = 1'b1; data1 = 4'b0101;
        tick();
        load1 = 1'b0;
        exp1("ign0", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        tick();
        load1 = 1'b1; data1 = 4'b1111;
        exp1("ign1", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
        tick();
        load1 = 1'b0;
        exp1("ign2", 1'b0, 1'b1, 1'b0, 2'd2, 1'b1);
        chk("ign_in", {4'h0, in1}, 8'h05);
        tick();
        exp1("ign3", 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
        tick();
        exp1("ign_end", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

        // asynchronous reset mid-frame at sel=10
        load1 = 1'b1; data1 = 4'b1011;
        tick();
        load1 = 1'b0;
        tick();
        tick();
        exp1("pre_rst", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp1("async_rst", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("async_rst_in", {4'h0, in1}, 8'h00);
        #1 rst = 1'b0;
        tick();
        exp1("post_rst", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        load1 = 1'b1; data1 = 4'b0100;
        tick();
        load1 = 1'b0;
        frame1("f0100", 4'b0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
